// File: rtl/pc_stack_reg.sv
// Program-counter register with sequential, jump, branch, call and return modes.
// A circular return-address stack backs CALL/RET; the oldest entry is overwritten on overflow.
module pc_stack_reg #(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               DEPTH     = 4
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    input  logic                     EN,
    input  logic [2:0]               OP,
    input  logic [WIDTH-1:0]         TARGET,
    input  logic [WIDTH-1:0]         OFFSET,
    output logic [WIDTH-1:0]         PC,
    output logic [$clog2(DEPTH):0]   STK_CNT,
    output logic                     STK_FULL,
    output logic                     STK_EMPTY,
    output logic [1:0]               ERR
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BR   = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HOLD = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_OVF     = 2'b01,
        ERR_UNF     = 2'b10,
        ERR_ILLEGAL = 2'b11
    } err_e;

    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [WIDTH-1:0] pc_q, pc_next;
    logic [PW-1:0]    sp_q, sp_next;      // next free slot; top of stack is sp_q-1
    logic [CW-1:0]    cnt_q, cnt_next;
    err_e             err_q, err_next;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic [PW-1:0]    top_addr;
    logic             full, empty;

    assign top_addr = sp_q - PW'(1);
    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);

    // NOTE: every output of this block gets a default first, so no path can leave a value unassigned and infer a latch.
    always_comb begin
        pc_next   = pc_q;
        sp_next   = sp_q;
        cnt_next  = cnt_q;
        err_next  = ERR_NONE;
        push      = 1'b0;
        push_data = pc_q + STEP_W;
        if (EN) begin
            case (OP)
                OP_SEQ:  pc_next = pc_q + STEP_W;
                OP_JMP:  pc_next = TARGET;
                OP_BR:   pc_next = pc_q + OFFSET;
                OP_CALL: begin
                    push    = 1'b1;
                    sp_next = sp_q + PW'(1);
                    pc_next = TARGET;
                    if (full) err_next = ERR_OVF;
                    else      cnt_next = cnt_q + CW'(1);
                end
                OP_RET: begin
                    if (empty) begin
                        err_next = ERR_UNF;
                    end else begin
                        pc_next  = stack_mem[top_addr];
                        sp_next  = top_addr;
                        cnt_next = cnt_q - CW'(1);
                    end
                end
                OP_HOLD: ;
                default: err_next = ERR_ILLEGAL;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            pc_q  <= RESET_VEC;
            sp_q  <= '0;
            cnt_q <= '0;
            err_q <= ERR_NONE;
        end else begin
            pc_q  <= pc_next;
            sp_q  <= sp_next;
            cnt_q <= cnt_next;
            err_q <= err_next;
        end
    end

    // NOTE: the stack array has no reset; entries are only read after a push makes them valid.
    always_ff @(posedge CLK) begin
        if (RST_n && push) stack_mem[sp_q] <= push_data;
    end

    assign PC        = pc_q;
    assign STK_CNT   = cnt_q;
    assign STK_FULL  = full;
    assign STK_EMPTY = empty;
    assign ERR       = err_q;

endmodule

// File: tb/tb_pc_stack_reg.sv
// Bench for pc_stack_reg: a 32-bit and an 8-bit instance share one stimulus stream;
// directed scenarios check literal values, a random run checks against a queue-based model.
module tb_pc_stack_reg;

    localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3,
                           RET = 3'd4, HOLD = 3'd5;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        EN = 1'b0;
    logic [2:0]  OP = SEQ;
    logic [31:0] TARGET = '0;
    logic [31:0] OFFSET = '0;

    logic [31:0] pc32;
    logic [2:0]  cnt32;
    logic        full32, empty32;
    logic [1:0]  err32;
    logic [7:0]  pc8;
    logic [2:0]  cnt8;
    logic        full8, empty8;
    logic [1:0]  err8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    pc_stack_reg #(.WIDTH(32), .STEP(4), .RESET_VEC(32'h100), .DEPTH(4)) dut32 (
        .CLK(CLK), .RST_n(RST_n), .EN(EN), .OP(OP), .TARGET(TARGET), .OFFSET(OFFSET),
        .PC(pc32), .STK_CNT(cnt32), .STK_FULL(full32), .STK_EMPTY(empty32), .ERR(err32)
    );

    pc_stack_reg #(.WIDTH(8), .STEP(4), .RESET_VEC(8'hF8), .DEPTH(4)) dut8 (
        .CLK(CLK), .RST_n(RST_n), .EN(EN), .OP(OP), .TARGET(TARGET[7:0]), .OFFSET(OFFSET[7:0]),
        .PC(pc8), .STK_CNT(cnt8), .STK_FULL(full8), .STK_EMPTY(empty8), .ERR(err8)
    );

    // Reference model: PC values per instance plus a bounded LIFO of return-address pairs.
    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  b;
    } ent_t;
    ent_t        m_stk[$];
    logic [31:0] m_pc32;
    logic [7:0]  m_pc8;
    logic [1:0]  m_err;

    task automatic model(input logic rst_n, input logic en, input logic [2:0] op,
                         input logic [31:0] tgt, input logic [31:0] off);
        ent_t e;
        if (!rst_n) begin
            m_pc32 = 32'h100;
            m_pc8  = 8'hF8;
            m_stk.delete();
            m_err  = 2'b00;
        end else if (!en) begin
            m_err = 2'b00;
        end else begin
            m_err = 2'b00;
            case (op)
                SEQ: begin m_pc32 = m_pc32 + 32'd4; m_pc8 = m_pc8 + 8'd4; end
                JMP: begin m_pc32 = tgt; m_pc8 = tgt[7:0]; end
                BR:  begin m_pc32 = m_pc32 + off; m_pc8 = m_pc8 + off[7:0]; end
                CALL: begin
                    if (m_stk.size() == 4) begin
                        void'(m_stk.pop_front());
                        m_err = 2'b01;
                    end
                    e.a = m_pc32 + 32'd4;
                    e.b = m_pc8 + 8'd4;
                    m_stk.push_back(e);
                    m_pc32 = tgt;
                    m_pc8  = tgt[7:0];
                end
                RET: begin
                    if (m_stk.size() == 0) begin
                        m_err = 2'b10;
                    end else begin
                        e = m_stk.pop_back();
                        m_pc32 = e.a;
                        m_pc8  = e.b;
                    end
                end
                HOLD: ;
                default: m_err = 2'b11;
            endcase
        end
    endtask

    task automatic step(input logic rst_n, input logic en, input logic [2:0] op,
                        input logic [31:0] tgt, input logic [31:0] off);
        RST_n  = rst_n;
        EN     = en;
        OP     = op;
        TARGET = tgt;
        OFFSET = off;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        step(1'b0, 1'b1, SEQ, '0, '0);
        step(1'b0, 1'b1, SEQ, '0, '0);
        n_checks++;
        if (pc32 !== 32'h100 || cnt32 !== 3'd0 || empty32 !== 1'b1 || full32 !== 1'b0 || err32 !== 2'b00)
            $display("FAIL reset32: pc=%h cnt=%0d empty=%b full=%b err=%b, want pc=00000100 cnt=0 empty=1 full=0 err=00",
                     pc32, cnt32, empty32, full32, err32);
        else n_pass++;
        n_checks++;
        if (pc8 !== 8'hF8 || cnt8 !== 3'd0 || empty8 !== 1'b1 || err8 !== 2'b00)
            $display("FAIL reset8: pc=%h cnt=%0d empty=%b err=%b, want pc=f8 cnt=0 empty=1 err=00",
                     pc8, cnt8, empty8, err8);
        else n_pass++;
    endtask

    task automatic test_seq;
        logic [31:0] exp_pc [3] = '{32'h104, 32'h108, 32'h10C};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, SEQ, '0, '0);
            n_checks++;
            if (pc32 !== exp_pc[i] || empty32 !== 1'b1 || err32 !== 2'b00)
                $display("FAIL seq[%0d]: pc=%h empty=%b err=%b, want pc=%h empty=1 err=00",
                         i, pc32, empty32, err32, exp_pc[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall_and_reset_priority;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, JMP, 32'h2000, '0);
            n_checks++;
            if (pc32 !== 32'h10C || err32 !== 2'b00)
                $display("FAIL stall[%0d]: pc=%h err=%b, want pc=0000010c err=00", i, pc32, err32);
            else n_pass++;
        end
        step(1'b0, 1'b1, JMP, 32'h2000, '0);
        n_checks++;
        if (pc32 !== 32'h100 || cnt32 !== 3'd0)
            $display("FAIL reset_priority: pc=%h cnt=%0d, want pc=00000100 cnt=0", pc32, cnt32);
        else n_pass++;
    endtask

    task automatic test_branch_wrap;
        logic [2:0] ops    [3] = '{SEQ, SEQ, BR};
        logic [7:0] exp_pc [3] = '{8'hFC, 8'h00, 8'hF0};
        step(1'b0, 1'b1, SEQ, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, ops[i], '0, 32'hFFFF_FFF0);
            n_checks++;
            if (pc8 !== exp_pc[i] || err8 !== 2'b00)
                $display("FAIL wrap8[%0d]: pc=%h err=%b, want pc=%h err=00", i, pc8, err8, exp_pc[i]);
            else n_pass++;
        end
    endtask

    task automatic test_call_return;
        logic [2:0]  ops     [4] = '{CALL, CALL, RET, RET};
        logic [31:0] tgts    [4] = '{32'h200, 32'h300, 32'h0, 32'h0};
        logic [31:0] exp_pc  [4] = '{32'h200, 32'h300, 32'h204, 32'h104};
        logic [2:0]  exp_cnt [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
        step(1'b0, 1'b1, SEQ, '0, '0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, ops[i], tgts[i], '0);
            n_checks++;
            if (pc32 !== exp_pc[i] || cnt32 !== exp_cnt[i] || err32 !== 2'b00)
                $display("FAIL callret[%0d]: pc=%h cnt=%0d err=%b, want pc=%h cnt=%0d err=00",
                         i, pc32, cnt32, err32, exp_pc[i], exp_cnt[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow_underflow;
        logic [31:0] exp_ret [4] = '{32'h44, 32'h34, 32'h24, 32'h14};
        step(1'b0, 1'b1, SEQ, '0, '0);
        step(1'b1, 1'b1, JMP, 32'h0, '0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, CALL, 32'(i * 16), '0);
            n_checks++;
            if (pc32 !== 32'(i * 16) || cnt32 !== 3'((i > 4) ? 4 : i) || err32 !== ((i == 5) ? 2'b01 : 2'b00)
                || full32 !== (i >= 4))
                $display("FAIL call_ovf[%0d]: pc=%h cnt=%0d full=%b err=%b, want pc=%h cnt=%0d full=%b err=%b",
                         i, pc32, cnt32, full32, err32, 32'(i * 16), (i > 4) ? 4 : i, (i >= 4),
                         (i == 5) ? 2'b01 : 2'b00);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, RET, '0, '0);
            n_checks++;
            if (pc32 !== exp_ret[i] || cnt32 !== 3'(3 - i) || err32 !== 2'b00)
                $display("FAIL ret_lifo[%0d]: pc=%h cnt=%0d err=%b, want pc=%h cnt=%0d err=00",
                         i, pc32, cnt32, err32, exp_ret[i], 3 - i);
            else n_pass++;
        end
        step(1'b1, 1'b1, RET, '0, '0);
        n_checks++;
        if (pc32 !== 32'h14 || cnt32 !== 3'd0 || empty32 !== 1'b1 || err32 !== 2'b10)
            $display("FAIL underflow: pc=%h cnt=%0d empty=%b err=%b, want pc=00000014 cnt=0 empty=1 err=10",
                     pc32, cnt32, empty32, err32);
        else n_pass++;
    endtask

    task automatic test_illegal_op;
        step(1'b0, 1'b1, SEQ, '0, '0);
        step(1'b1, 1'b1, SEQ, '0, '0);
        for (int i = 6; i <= 7; i++) begin
            step(1'b1, 1'b1, 3'(i), 32'h5000, 32'h40);
            n_checks++;
            if (pc32 !== 32'h104 || err32 !== 2'b11)
                $display("FAIL illegal_op%0d: pc=%h err=%b, want pc=00000104 err=11", i, pc32, err32);
            else n_pass++;
        end
        step(1'b1, 1'b0, SEQ, '0, '0);
        n_checks++;
        if (pc32 !== 32'h104 || err32 !== 2'b00)
            $display("FAIL err_clear_on_stall: pc=%h err=%b, want pc=00000104 err=00", pc32, err32);
        else n_pass++;
        step(1'b1, 1'b1, 3'd7, '0, '0);
        step(1'b1, 1'b1, SEQ, '0, '0);
        n_checks++;
        if (pc32 !== 32'h108 || err32 !== 2'b00)
            $display("FAIL illegal_then_seq: pc=%h err=%b, want pc=00000108 err=00", pc32, err32);
        else n_pass++;
    endtask

    task automatic test_random;
        logic        rst_n, en;
        logic [2:0]  op;
        logic [31:0] tgt, off;
        model(1'b0, 1'b1, SEQ, '0, '0);
        step(1'b0, 1'b1, SEQ, '0, '0);
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            en    = ($urandom_range(0, 7) != 0);
            op    = 3'($urandom_range(0, 7));
            tgt   = $urandom;
            off   = $urandom;
            model(rst_n, en, op, tgt, off);
            step(rst_n, en, op, tgt, off);
            n_checks++;
            if (pc32 !== m_pc32 || cnt32 !== 3'(m_stk.size()) || full32 !== (m_stk.size() == 4)
                || empty32 !== (m_stk.size() == 0) || err32 !== m_err)
                $display("FAIL rand32[%0d]: pc=%h cnt=%0d full=%b empty=%b err=%b, want pc=%h cnt=%0d err=%b",
                         i, pc32, cnt32, full32, empty32, err32, m_pc32, m_stk.size(), m_err);
            else n_pass++;
            n_checks++;
            if (pc8 !== m_pc8 || cnt8 !== 3'(m_stk.size()) || full8 !== (m_stk.size() == 4)
                || empty8 !== (m_stk.size() == 0) || err8 !== m_err)
                $display("FAIL rand8[%0d]: pc=%h cnt=%0d full=%b empty=%b err=%b, want pc=%h cnt=%0d err=%b",
                         i, pc8, cnt8, full8, empty8, err8, m_pc8, m_stk.size(), m_err);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_stall_and_reset_priority();
        test_branch_wrap();
        test_call_return();
        test_overflow_underflow();
        test_illegal_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_stack_reg.md
Name: pc_stack_reg

Overview:
Parametrised program-counter register, the successor to the single-bit D flip-flop experiments. It holds a WIDTH-bit PC that updates on each enabled clock edge in one of several modes: sequential increment, absolute jump, relative branch, call and return. A DEPTH-entry return-address stack backs the call and return modes. It sits between the instruction-fetch address mux and the instruction memory of the lab CPU datapath.

Parameters:
WIDTH, 32, PC and address width in bits (range 8..64).
STEP, 4, sequential increment added to the PC.
RESET_VEC, 0, PC value loaded on reset.
DEPTH, 4, return-stack entries (power of 2, 2..16).

Ports:
CLK  in  1  system clock; all state changes on the rising edge.
RST_n  in  1  synchronous reset, active-low; sampled on CLK rising edge.
EN  in  1  update enable; 0 = stall, all state holds.
OP  in  3  0 SEQ, 1 JMP, 2 BR, 3 CALL, 4 RET, 5 HOLD, 6/7 reserved.
TARGET  in  WIDTH  absolute address for JMP and CALL.
OFFSET  in  WIDTH  two's-complement offset for BR.
PC  out  WIDTH  current program counter (registered).
STK_CNT  out  $clog2(DEPTH)+1  number of valid stack entries.
STK_FULL  out  1  STK_CNT == DEPTH (combinational from the count register).
STK_EMPTY  out  1  STK_CNT == 0.
ERR  out  2  one-cycle error pulse: 00 none, 01 overflow, 10 underflow, 11 illegal OP.

Behaviour:
- Reset is synchronous and active-low. On a CLK rising edge with RST_n=0: PC=RESET_VEC, STK_CNT=0, stack pointer=0, ERR=00. Stack contents are don't-care. Reset has priority over EN and OP. RST_n low between edges has no effect until the next edge.
- EN=0 at an edge: PC, stack and count hold; ERR=00.
- EN=1, per OP at the edge:
  - SEQ: PC <= PC+STEP.
  - JMP: PC <= TARGET.
  - BR: PC <= PC+OFFSET.
  - CALL: push PC+STEP; PC <= TARGET.
  - RET: PC <= top entry; pop.
  - HOLD: no change.
  - 6/7: no change; ERR=11 for one cycle.
- Arithmetic is modulo 2^WIDTH with silent wrap. Example: WIDTH=8, PC=8'hFE, SEQ with STEP=4 gives 8'h02. No error is flagged for wrap.
- Latency: one cycle. The new PC is visible on PC immediately after the edge. No combinational path from inputs to PC.
- Stack is circular, with the write pointer wrapping mod DEPTH.
  - CALL when full: the push still happens and overwrites the oldest entry. STK_CNT stays DEPTH. PC <= TARGET. ERR=01.
  - RET when empty: PC holds, count stays 0, ERR=10.
  - A push followed by a pop returns entries in LIFO order, including after an overflow wrap; the most recent DEPTH entries survive.
- ERR is registered. It is nonzero only in the cycle following the offending edge and returns to 00 at the next enabled or stalled edge.
- Only one OP is accepted per edge, so push and pop never coincide.

Test Plan:
1. Reset and sequencing (WIDTH=32, RESET_VEC=32'h100): RST_n=0 for 2 edges, then SEQ×3 -> PC 100,104,108,10C; STK_EMPTY=1; ERR=00 throughout.
2. Stall and reset priority: EN=0 with OP=JMP, TARGET=32'h2000 for 3 edges -> PC unchanged. Then RST_n=0 with EN=1 and OP=JMP -> PC=32'h100 after that edge.
3. Branch and wrap (WIDTH=8, RESET_VEC=8'hF8): SEQ -> FC; SEQ -> 00; BR OFFSET=8'hF0 (-16) -> F0. No ERR.
4. Call/return nesting (DEPTH=4): from PC=100, CALL 200, CALL 300, RET, RET -> PC 200,300,204,104. STK_CNT 1,2,1,0.
5. Overflow and underflow (DEPTH=4): 5 CALLs from PC=0 to targets 10,20,30,40,50. The 5th gives ERR=01 for one cycle with STK_CNT=4. Then 4 RETs -> PC 44,34,24,14. A 5th RET -> PC stays 14, ERR=10, STK_CNT=0.
6. Illegal OP: OP=6 then OP=7 at PC=104 -> PC holds 104, ERR=11 on each following cycle. Then SEQ -> PC=108, ERR=00.
